// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_pkg
// Description : Shared types and constants for the SHA-256d sweep controller
//               and the two-phase hash core.
// Revision    : 1.0 - initial release
// ============================================================================
package sha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_KICK  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CLEAR = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Element [0] is H0
    localparam logic [7:0][31:0] C_SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] C_PAD_WORD     = 32'h8000_0000;
    localparam logic [31:0] C_LEN_PHASE1   = 32'd640;
    localparam logic [31:0] C_LEN_PHASE2   = 32'd256;

endpackage : sha_pkg
`default_nettype wire

// File: rtl/nonce_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nonce_sweep_ctrl
// Description : Sweeps a nonce range through the two-phase SHA-256 core,
//               stores each H0 and records the first nonce meeting target.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_sweep_ctrl
    import sha_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [7:0][31:0]       midstate,
    input  logic [2:0][31:0]       tail,
    input  logic [31:0]            nonce_first,
    input  logic [31:0]            nonce_count,
    input  logic [31:0]            target,
    input  logic [ADDR_W-1:0]      out_addr,
    output logic                   core_reset_n,
    output logic                   core_start,
    output logic [7:0][31:0]       core_inh,
    output logic [3:0][31:0]       core_message,
    input  logic [7:0][31:0]       core_outs,
    input  logic                   core_done,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_write_data,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [31:0]            found_nonce,
    output logic                   error
);

    localparam int                WAIT_W      = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_e              r_state;
    logic [7:0][31:0]    r_inh;
    logic [2:0][31:0]    r_tail;
    logic [31:0]         r_target;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_nonce;
    logic [31:0]         r_remaining;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_core_reset_n;
    logic                r_found;
    logic [31:0]         r_found_nonce;
    logic                r_error;
    logic                w_hit;
    logic                w_unused_outs;

    assign w_hit         = (core_outs[0] <= r_target) && !r_found;
    assign w_unused_outs = ^core_outs[7:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_inh          <= '0;
            r_tail         <= '0;
            r_target       <= '0;
            r_base         <= '0;
            r_idx          <= '0;
            r_nonce        <= '0;
            r_remaining    <= '0;
            r_wait         <= '0;
            r_core_reset_n <= 1'b0;
            r_found        <= 1'b0;
            r_found_nonce  <= '0;
            r_error        <= 1'b0;
        end else begin
            // Core reset is a registered strobe: low only for the CLEAR cycle
            r_core_reset_n <= 1'b1;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_inh         <= midstate;
                        r_tail        <= tail;
                        r_target      <= target;
                        r_base        <= out_addr;
                        r_nonce       <= nonce_first;
                        r_remaining   <= nonce_count;
                        r_idx         <= '0;
                        r_found       <= 1'b0;
                        r_found_nonce <= '0;
                        r_error       <= 1'b0;
                        r_state       <= (nonce_count == 32'd0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: r_state <= ST_KICK;
                ST_KICK: begin
                    r_wait  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the last allowed cycle still wins
                    if (core_done) begin
                        r_state <= ST_WRITE;
                    end else if (r_wait == C_WAIT_LAST) begin
                        r_error        <= 1'b1;
                        r_core_reset_n <= 1'b0;
                        r_state        <= ST_CLEAR;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_hit) begin
                        r_found       <= 1'b1;
                        r_found_nonce <= r_nonce;
                    end
                    r_core_reset_n <= 1'b0;
                    r_state        <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    r_nonce     <= r_nonce + 32'd1;
                    r_idx       <= r_idx + 1'b1;
                    r_remaining <= r_remaining - 32'd1;
                    r_state     <= (r_error || r_remaining == 32'd1) ? ST_DONE : ST_LOAD;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign core_reset_n      = r_core_reset_n;
    assign core_start        = (r_state == ST_KICK);
    assign core_inh          = r_inh;
    assign core_message[0]   = r_tail[0];
    assign core_message[1]   = r_tail[1];
    assign core_message[2]   = r_tail[2];
    assign core_message[3]   = r_nonce;

    assign mem_we            = (r_state == ST_WRITE);
    assign mem_addr          = mem_we ? (r_base + r_idx) : '0;
    assign mem_write_data    = mem_we ? core_outs[0] : '0;

    assign busy              = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done              = (r_state == ST_DONE);
    assign found             = r_found;
    assign found_nonce       = r_found_nonce;
    assign error             = r_error;

endmodule : nonce_sweep_ctrl
`default_nettype wire

// File: tb/tb_nonce_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_sweep_ctrl
// Description : Directed bench for nonce_sweep_ctrl with a behavioural core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_sweep_ctrl;

    localparam int ADDR_W = 16;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                start;
    logic [7:0][31:0]    midstate;
    logic [2:0][31:0]    tail;
    logic [31:0]         nonce_first;
    logic [31:0]         nonce_count;
    logic [31:0]         target;
    logic [ADDR_W-1:0]   out_addr;
    logic                core_reset_n;
    logic                core_start;
    logic [7:0][31:0]    core_inh;
    logic [3:0][31:0]    core_message;
    logic [7:0][31:0]    core_outs;
    logic                core_done;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_write_data;
    logic                busy;
    logic                done;
    logic                found;
    logic [31:0]         found_nonce;
    logic                error;

    int checks   = 0;
    int failures = 0;

    nonce_sweep_ctrl #(.ADDR_W(ADDR_W), .WAIT_LIMIT(255)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .midstate       (midstate),
        .tail           (tail),
        .nonce_first    (nonce_first),
        .nonce_count    (nonce_count),
        .target         (target),
        .out_addr       (out_addr),
        .core_reset_n   (core_reset_n),
        .core_start     (core_start),
        .core_inh       (core_inh),
        .core_message   (core_message),
        .core_outs      (core_outs),
        .core_done      (core_done),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .busy           (busy),
        .done           (done),
        .found          (found),
        .found_nonce    (found_nonce),
        .error          (error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] h0_model(input logic [31:0] n);
        return (n * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    // Behavioural core: done rises core_lat edges after the start pulse
    int          core_lat   = 8;
    bit          never_done = 1'b0;
    int          core_cnt;
    always @(posedge clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            core_done <= 1'b0;
            core_cnt  <= 0;
            core_outs <= '0;
        end else if (core_start) begin
            core_cnt     <= never_done ? 0 : core_lat;
            core_outs[0] <= h0_model(core_message[3]);
            for (int k = 1; k < 8; k++) core_outs[k] <= 32'hC0DE_0000 + k;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_done <= 1'b1;
        end
    end

    logic [31:0]  wr_addr_q[$];
    logic [31:0]  wr_data_q[$];
    logic [31:0]  nonce_q[$];
    logic [31:0]  msg_tail0, msg_tail1, msg_tail2, inh0, inh7;
    int           done_rises = 0;
    logic         done_q     = 1'b0;
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(32'(mem_addr));
            wr_data_q.push_back(mem_write_data);
        end
        if (core_start) begin
            nonce_q.push_back(core_message[3]);
            msg_tail0 = core_message[0];
            msg_tail1 = core_message[1];
            msg_tail2 = core_message[2];
            inh0      = core_inh[0];
            inh7      = core_inh[7];
        end
        if (done && !done_q) done_rises++;
        done_q = done;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int w0, s0, r0;

    task automatic kick_sweep(input logic [31:0] first, input logic [31:0] count,
                              input logic [31:0] tgt, input logic [ADDR_W-1:0] base);
        w0 = wr_addr_q.size();
        s0 = nonce_q.size();
        r0 = done_rises;
        @(negedge clk);
        nonce_first = first;
        nonce_count = count;
        target      = tgt;
        out_addr    = base;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        target      = ~tgt;
    endtask

    task automatic run_sweep(input logic [31:0] first, input logic [31:0] count,
                             input logic [31:0] tgt, input logic [ADDR_W-1:0] base,
                             input int budget, input string tag);
        bit timed_out;
        kick_sweep(first, count, tgt, base);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check_val({tag, "_timeout"}, 64'(timed_out), 64'd0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] first_hit(input logic [31:0] first, input int count,
                                              input logic [31:0] tgt);
        for (int i = 0; i < count; i++)
            if (h0_model(first + 32'(i)) <= tgt) return first + 32'(i);
        return 32'd0;
    endfunction

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        nonce_first = '0;
        nonce_count = '0;
        target      = '0;
        out_addr    = '0;
        for (int k = 0; k < 8; k++) midstate[k] = 32'h1111_1111 * (k + 1);
        tail[0] = 32'hAAAA_0001;
        tail[1] = 32'hBBBB_0002;
        tail[2] = 32'hCCCC_0003;

        repeat (3) @(negedge clk);
        check_val("rst_core_reset_n", 64'(core_reset_n), 64'd0);
        check_val("rst_busy",         64'(busy),         64'd0);
        check_val("rst_done",         64'(done),         64'd0);
        check_val("rst_mem_we",       64'(mem_we),       64'd0);
        check_val("rst_core_start",   64'(core_start),   64'd0);
        check_val("rst_found",        64'(found),        64'd0);
        check_val("rst_error",        64'(error),        64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_core_reset_n", 64'(core_reset_n), 64'd1);

        // Basic sweep of three nonces
        run_sweep(32'd5, 32'd3, 32'd0, 16'h0100, 200, "t1");
        check_val("t1_writes", 64'(wr_addr_q.size() - w0), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t1_addr%0d", i),  64'(wr_addr_q[w0+i]), 64'(32'h100 + i));
            check_val($sformatf("t1_data%0d", i),  64'(wr_data_q[w0+i]), 64'(h0_model(32'd5 + i)));
            check_val($sformatf("t1_nonce%0d", i), 64'(nonce_q[s0+i]),   64'(32'd5 + i));
        end
        check_val("t1_done_rises", 64'(done_rises - r0), 64'd1);
        check_val("t1_found",      64'(found), 64'd0);
        check_val("t1_msg0",       64'(msg_tail0), 64'(tail[0]));
        check_val("t1_msg1",       64'(msg_tail1), 64'(tail[1]));
        check_val("t1_msg2",       64'(msg_tail2), 64'(tail[2]));
        check_val("t1_inh0",       64'(inh0), 64'(midstate[0]));
        check_val("t1_inh7",       64'(inh7), 64'(midstate[7]));

        // Every nonce hits; only the first is recorded
        run_sweep(32'd9, 32'd4, 32'hFFFF_FFFF, 16'h0200, 300, "t2");
        check_val("t2_writes",      64'(wr_addr_q.size() - w0), 64'd4);
        check_val("t2_found",       64'(found),       64'd1);
        check_val("t2_found_nonce", 64'(found_nonce), 64'd9);

        // No nonce hits
        run_sweep(32'd9, 32'd4, 32'd0, 16'h0200, 300, "t3");
        check_val("t3_writes",      64'(wr_addr_q.size() - w0), 64'd4);
        check_val("t3_found",       64'(found),       64'd0);
        check_val("t3_found_nonce", 64'(found_nonce), 64'd0);

        // Target equal to one hash value: the <= boundary
        run_sweep(32'd9, 32'd4, h0_model(32'd11), 16'h0200, 300, "t3b");
        check_val("t3b_found",       64'(found),       64'd1);
        check_val("t3b_found_nonce", 64'(found_nonce), 64'(first_hit(32'd9, 4, h0_model(32'd11))));

        // Nonce and address wrap
        run_sweep(32'hFFFF_FFFE, 32'd3, 32'd0, 16'hFFFF, 300, "t4");
        check_val("t4_nonce0", 64'(nonce_q[s0]),   64'hFFFF_FFFE);
        check_val("t4_nonce1", 64'(nonce_q[s0+1]), 64'hFFFF_FFFF);
        check_val("t4_nonce2", 64'(nonce_q[s0+2]), 64'h0000_0000);
        check_val("t4_addr0",  64'(wr_addr_q[w0]),   64'hFFFF);
        check_val("t4_addr1",  64'(wr_addr_q[w0+1]), 64'h0000);
        check_val("t4_addr2",  64'(wr_addr_q[w0+2]), 64'h0001);

        // Watchdog abort with a core that never finishes
        never_done = 1'b1;
        run_sweep(32'd1, 32'd3, 32'hFFFF_FFFF, 16'h0000, 2000, "t5");
        check_val("t5_error",  64'(error), 64'd1);
        check_val("t5_writes", 64'(wr_addr_q.size() - w0), 64'd0);
        check_val("t5_done",   64'(done),  64'd1);
        check_val("t5_starts", 64'(nonce_q.size() - s0), 64'd1);
        check_val("t5_found",  64'(found), 64'd0);
        never_done = 1'b0;

        // Done on the final allowed WAIT cycle beats the watchdog
        core_lat = 254;
        run_sweep(32'd1, 32'd1, 32'd0, 16'h0000, 1000, "t6");
        check_val("t6_error",  64'(error), 64'd0);
        check_val("t6_writes", 64'(wr_addr_q.size() - w0), 64'd1);
        // One cycle later is too late
        core_lat = 255;
        run_sweep(32'd1, 32'd1, 32'd0, 16'h0000, 1000, "t6b");
        check_val("t6b_error",  64'(error), 64'd1);
        check_val("t6b_writes", 64'(wr_addr_q.size() - w0), 64'd0);
        core_lat = 8;

        // Empty range
        run_sweep(32'd7, 32'd0, 32'd0, 16'h0000, 2, "t7");
        check_val("t7_done",   64'(done), 64'd1);
        check_val("t7_starts", 64'(nonce_q.size() - s0), 64'd0);
        check_val("t7_error",  64'(error), 64'd0);

        // Reset during the second WAIT
        kick_sweep(32'd20, 32'd4, 32'd0, 16'h0300);
        for (int i = 0; i < 200 && nonce_q.size() - s0 < 2; i++) @(negedge clk);
        check_val("t8_reached_second", 64'(nonce_q.size() - s0), 64'd2);
        repeat (3) @(negedge clk);
        check_val("t8_in_wait_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_val("t8_core_reset_n", 64'(core_reset_n), 64'd0);
        check_val("t8_busy",         64'(busy),         64'd0);
        check_val("t8_writes_at_rst", 64'(wr_addr_q.size() - w0), 64'd1);
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check_val("t8_writes_after", 64'(wr_addr_q.size() - w0), 64'd1);
        check_val("t8_busy_after",   64'(busy), 64'd0);
        check_val("t8_done_after",   64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nonce_sweep_ctrl
`default_nettype wire

// File: doc/nonce_sweep_ctrl.md
Name: nonce_sweep_ctrl

Overview:
- Upstream/downstream control stage for the two-phase SHA-256 hash core.
- For each nonce in a programmed range, builds the core inputs (midstate plus the three tail words plus the nonce) and pulses the core start.
- Waits for the core's done, writes hash word H0 to memory and tracks the first nonce whose H0 meets a 32-bit target.
- Clears the core between nonces through a dedicated core reset, because the core holds done until it is reset.

Parameters:
- ADDR_W, 16: memory write address width.
- WAIT_LIMIT, 255: maximum cycles spent in WAIT before the error abort.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- midstate  in  32x8  phase-1 chaining value, copied to core_inh
- tail  in  32x3  block-2 message words 16..18
- nonce_first  in  32  first nonce
- nonce_count  in  32  number of nonces to hash
- target  in  32  a hit is H0 <= target (unsigned)
- out_addr  in  ADDR_W  base address for H0 results
- core_reset_n  out  1  core reset: low during reset_n, and low for one cycle in CLEAR
- core_start  out  1  one-cycle pulse to the core
- core_inh  out  32x8  registered midstate
- core_message  out  32x4  {tail[0], tail[1], tail[2], nonce}
- core_outs  in  32x8  core hash result
- core_done  in  1  core done (level, held until core reset)
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  write address
- mem_write_data  out  32  H0 of the current nonce
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE; held until the next start
- found  out  1  at least one hit seen this sweep
- found_nonce  out  32  first hitting nonce
- error  out  1  watchdog abort occurred

Behaviour:
- Reset values: all outputs 0, except core_reset_n, which is forced low asynchronously while reset_n is low. State goes to IDLE.
- IDLE:
  - On start, latch midstate, tail, target and out_addr; set nonce = nonce_first, remaining = nonce_count, idx = 0.
  - Clear found, found_nonce, error and done.
  - Go to DONE if nonce_count == 0, otherwise go to LOAD.
- LOAD: drive core_message with the current nonce; go to KICK.
- KICK: core_start = 1 for exactly one cycle; clear the wait counter; go to WAIT.
- WAIT:
  - When core_done = 1, go to WRITE.
  - Otherwise increment the wait counter. When it reaches WAIT_LIMIT, set error = 1 and go to CLEAR, then DONE, without writing.
- WRITE (one cycle):
  - mem_we = 1, mem_addr = out_addr + idx (mod 2^ADDR_W), mem_write_data = core_outs[0].
  - If core_outs[0] <= target and found == 0: set found = 1 and found_nonce = nonce. Later hits do not change found_nonce.
  - Go to CLEAR.
- CLEAR:
  - core_reset_n = 0 for one cycle (registered low, so it is glitch-free).
  - nonce++ (wraps 0xFFFFFFFF -> 0), idx++, remaining--.
  - Go to LOAD if remaining != 0, otherwise go to DONE.
- DONE:
  - done = 1; busy = 0.
  - On start, behave exactly as IDLE on start.
- Per-nonce cost is about 6 cycles plus the core latency (about 140 cycles).
- start is ignored while busy.
- core_done asserted outside WAIT is ignored.
- reset_n deasserted mid-sweep aborts immediately: no further writes, outputs return to their reset values.
- If target changes after start, the latched copy is used.
- A core_done that coincides with the watchdog limit counts as done: it takes priority over the error.

Decomposition:
- Package sha_pkg holds:
  - the state enum (IDLE, LOAD, KICK, WAIT, WRITE, CLEAR, DONE);
  - the SHA-256 IV constants;
  - the block-2 padding constants (0x80000000, length 640/256) shared with the core.
- No sub-module is needed: the watchdog counter stays inline.
- The top-level bitcoin_hash instantiates nonce_sweep_ctrl and twophase_sha256 side by side.

Test Plan:
- nonce_first = 5, nonce_count = 3, out_addr = 0x100, real core:
  - writes at 0x100..0x102 carrying core_message[3] = 5, 6, 7;
  - each data value equals the software SHA-256d H0;
  - done rises once after the third write.
- target = 0xFFFFFFFF, nonce_first = 9, nonce_count = 4:
  - found = 1 and found_nonce = 9, first hit only, after all 4 writes.
- target = 0, same range:
  - found = 0 and 4 writes.
- nonce_first = 0xFFFFFFFE, nonce_count = 3:
  - nonces FFFFFFFE, FFFFFFFF, 00000000 in order.
- Stub core that never asserts done:
  - error = 1 after 255 WAIT cycles, zero mem_we pulses, done = 1.
- nonce_count = 0:
  - done within 2 cycles, no core_start.
- reset_n pulsed low during the second WAIT:
  - core_reset_n low immediately, no further writes, busy = 0.
